// File: rtl/core_pkg.sv
// Shared types and constants for the memory arbiter slice: FSM state
// encoding, requester ids, default widths and the fixed-priority picker.
package core_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Requester ids; also the bit positions in a {d_req, i_req} vector.
    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_DATA  = 1'b1;

    // Fixed priority: data wins whenever it is requesting.
    function automatic logic pick_fixed(input logic [1:0] req);
        return req[REQ_DATA] ? REQ_DATA : REQ_FETCH;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, the data port and the memory port of the
// arbiter. slave = arbiter view, master = requesters plus memory view.
interface mem_arbiter_if
    import core_pkg::*;
#(
    parameter int unsigned AW = ADDR_W,
    parameter int unsigned DW = DATA_W
);

    // Fetch port
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;

    // Data port
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    // Memory port
    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output m_en, m_we, m_addr, m_wdata,
        input  m_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_en, m_we, m_addr, m_wdata,
        output m_rdata
    );

endinterface

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: on a tie the requester not granted last wins.
module arb_rr2
    import core_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner_c
);

    // Pick the single requester, or alternate against last on a tie.
    always_comb begin
        winner_c = REQ_FETCH;
        case (req)
            2'b01:   winner_c = REQ_FETCH;
            2'b10:   winner_c = REQ_DATA;
            2'b11:   winner_c = (last == REQ_DATA) ? REQ_FETCH : REQ_DATA;
            default: winner_c = REQ_FETCH;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter and access sequencer for a single-port,
// fixed-latency memory. Fetch is read-only, data is read/write.
// Build option: define ARB_RR_EN for round-robin arbitration on ties;
// otherwise data has fixed priority over fetch (fetch may starve).
module mem_arbiter
    import core_pkg::*;
#(
    parameter int unsigned AW      = ADDR_W,
    parameter int unsigned DW      = DATA_W,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_ext,
    mem_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
    localparam bit               HAS_WAIT = (MEM_LAT > 1);

    // Sequencer state and the latched access
    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             win_q;
    logic             win_d;
    logic             we_q;
    logic             we_d;
    logic [AW-1:0]    addr_q;
    logic [AW-1:0]    addr_d;
    logic [DW-1:0]    wdata_q;
    logic [DW-1:0]    wdata_d;

    // Arbitration
    logic [1:0]       req_vec;
    logic             take;
    logic             pick_c;

    // Output registers and their next values
    logic             i_gnt_q;
    logic             i_gnt_d;
    logic             d_gnt_q;
    logic             d_gnt_d;
    logic             i_rvalid_q;
    logic             i_rvalid_d;
    logic             d_rvalid_q;
    logic             d_rvalid_d;
    logic             m_en_q;
    logic             m_en_d;
    logic             m_we_q;
    logic             m_we_d;
    logic [DW-1:0]    i_rdata_q;
    logic [DW-1:0]    d_rdata_q;

    assign req_vec = {bus.d_req, bus.i_req};

`ifdef ARB_RR_EN
    logic last_q;

    arb_rr2 u_arb (
        .req      (req_vec),
        .last     (last_q),
        .winner_c (pick_c)
    );

    // Remember who won the last arbitration; reset favours fetch on the first tie.
    always_ff @(posedge clk) begin
        if (rst_ext) begin
            last_q <= REQ_DATA;
        end else if (take) begin
            last_q <= pick_c;
        end
    end
`else
    assign pick_c = pick_fixed(req_vec);
`endif

    // State register plus the latched winner, direction, address and data.
    always_ff @(posedge clk) begin
        if (rst_ext) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            win_q   <= REQ_FETCH;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next state, latency counter and capture of the winning request.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        take    = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req_vec) begin
                    take    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = HAS_WAIT ? WAIT : RESP;
            end
            WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                // Response cycle doubles as the next arbitration slot.
                if (|req_vec) begin
                    take    = 1'b1;
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (take) begin
            win_d = pick_c;
            if (pick_c == REQ_DATA) begin
                we_d    = bus.d_we;
                addr_d  = bus.d_addr;
                wdata_d = bus.d_wdata;
            end else begin
                we_d    = 1'b0;
                addr_d  = bus.i_addr;
                wdata_d = '0;
            end
        end
    end

    // Decode next-cycle strobes from the next state so they leave a register.
    always_comb begin
        m_en_d     = 1'b0;
        m_we_d     = 1'b0;
        i_gnt_d    = 1'b0;
        d_gnt_d    = 1'b0;
        i_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;

        if (state_d == ISSUE) begin
            m_en_d  = 1'b1;
            m_we_d  = we_d;
            i_gnt_d = (win_d == REQ_FETCH);
            d_gnt_d = (win_d == REQ_DATA);
        end
        if (state_d == RESP) begin
            i_rvalid_d = (win_d == REQ_FETCH);
            d_rvalid_d = (win_d == REQ_DATA);
        end
    end

    // Output strobes, plus read data held between response pulses.
    always_ff @(posedge clk) begin
        if (rst_ext) begin
            i_gnt_q    <= 1'b0;
            d_gnt_q    <= 1'b0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            m_en_q     <= 1'b0;
            m_we_q     <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            i_gnt_q    <= i_gnt_d;
            d_gnt_q    <= d_gnt_d;
            i_rvalid_q <= i_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            m_en_q     <= m_en_d;
            m_we_q     <= m_we_d;
            if (i_rvalid_q) begin
                i_rdata_q <= bus.m_rdata;
            end
            if (d_rvalid_q) begin
                d_rdata_q <= we_q ? '0 : bus.m_rdata;
            end
        end
    end

    assign bus.i_gnt    = i_gnt_q;
    assign bus.d_gnt    = d_gnt_q;
    assign bus.i_rvalid = i_rvalid_q;
    assign bus.d_rvalid = d_rvalid_q;
    assign bus.m_en     = m_en_q;
    assign bus.m_we     = m_we_q;
    assign bus.m_addr   = addr_q;
    assign bus.m_wdata  = wdata_q;

    // Memory data only arrives in the response cycle, so it is passed
    // straight through while rvalid is high and held afterwards.
    assign bus.i_rdata = i_rvalid_q ? bus.m_rdata : i_rdata_q;
    assign bus.d_rdata = d_rvalid_q ? (we_q ? '0 : bus.m_rdata) : d_rdata_q;

endmodule
